// File: rtl/cpu_wb.sv
// RV32 write-back stage: retires ALU results, waits for load responses, applies
// byte/halfword selection with sign/zero extension and drives the regfile write port.
module cpu_wb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_result_i,
    input  logic        ex_is_load_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [1:0]  ex_addr_lo_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        ld_pending_o,
    output logic [4:0]  ld_rd_o,
    output logic        err_o
);

    typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pend_q, pend_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        err_q, err_d;

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

    assign ex_ready_o = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        ld_rd_d = ld_rd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // A response arriving here has no owner and is dropped.
                if (ex_valid_i) begin
                    if (ex_is_load_i) begin
                        rd_d    = ex_rd_i;
                        f3_d    = ex_funct3_i;
                        lo_d    = ex_addr_lo_i;
                        cnt_d   = 8'd0;
                        pend_d  = 1'b1;
                        ld_rd_d = ex_rd_i;
                        state_d = WAIT_LOAD;
                    end else if (ex_rd_i != 5'd0) begin
                        we_d    = 1'b1;
                        waddr_d = ex_rd_i;
                        wdata_d = ex_result_i;
                    end
                end
            end
            WAIT_LOAD: begin
                // The response beats the timeout when both land in the same cycle.
                if (mem_rvalid_i) begin
                    if (rd_q != 5'd0) begin
                        we_d    = 1'b1;
                        waddr_d = rd_q;
                        wdata_d = load_extend(f3_q, lo_q, mem_rdata_i);
                    end
                    pend_d  = 1'b0;
                    ld_rd_d = 5'd0;
                    state_d = IDLE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                    ld_rd_d = 5'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
            lo_q    <= 2'd0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            pend_q  <= 1'b0;
            ld_rd_q <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            ld_rd_q <= ld_rd_d;
            err_q   <= err_d;
        end
    end

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign ld_pending_o = pend_q;
    assign ld_rd_o      = ld_rd_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_cpu_wb.sv
// Bench for cpu_wb: directed cases plus randomized ALU/load traffic checked
// against a transaction-level model of the write-back rules.
module tb_cpu_wb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [2:0]  ex_funct3_i;
    logic [1:0]  ex_addr_lo_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        ld_pending_o;
    logic [4:0]  ld_rd_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;
    logic [4:0]  b_rd  [8];
    logic [31:0] b_res [8];

    cpu_wb #(.TIMEOUT(TO)) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_rd_i      (ex_rd_i),
        .ex_result_i  (ex_result_i),
        .ex_is_load_i (ex_is_load_i),
        .ex_funct3_i  (ex_funct3_i),
        .ex_addr_lo_i (ex_addr_lo_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .ld_pending_o (ld_pending_o),
        .ld_rd_o      (ld_rd_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load extension using plain arithmetic on the response word.
    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(lo))) % 256;
        h = (lo >= 2) ? (w / 65536) : (w % 65536);
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(ex_ready_o), 32'd1);
        check({tag, "_pend"},  32'(ld_pending_o), 32'd0);
        check({tag, "_ldrd"},  32'(ld_rd_o), 32'd0);
        check({tag, "_err"},   32'(err_o), 32'(exp_err));
    endtask

    task automatic clear_inputs();
        ex_valid_i   = 1'b0;
        ex_is_load_i = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    // Issues n back-to-back ALU results from b_rd/b_res, one per cycle.
    task automatic alu_burst(input int n);
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                check("alu_we", 32'(we_o), 32'(b_rd[i-1] != 5'd0));
                if (b_rd[i-1] != 5'd0) begin
                    check("alu_waddr", 32'(waddr_o), 32'(b_rd[i-1]));
                    check("alu_wdata", wdata_o, b_res[i-1]);
                end
            end
            if (i < n) begin
                check("alu_ready", 32'(ex_ready_o), 32'd1);
                ex_valid_i   = 1'b1;
                ex_is_load_i = 1'b0;
                ex_rd_i      = b_rd[i];
                ex_result_i  = b_res[i];
                ex_funct3_i  = 3'($urandom);
                ex_addr_lo_i = 2'($urandom);
                @(negedge clk);
            end
        end
        clear_inputs();
        check_idle("alu_end");
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] word, input int delay, input bit rv_acc);
        check("ld_acc_ready", 32'(ex_ready_o), 32'd1);
        ex_valid_i   = 1'b1;
        ex_is_load_i = 1'b1;
        ex_rd_i      = rd;
        ex_funct3_i  = f3;
        ex_addr_lo_i = lo;
        ex_result_i  = $urandom;
        mem_rvalid_i = rv_acc;
        mem_rdata_i  = $urandom;
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i <= delay; i++) begin
            check("ld_wait_we", 32'(we_o), 32'd0);
            check("ld_wait_ready", 32'(ex_ready_o), 32'd0);
            check("ld_wait_pend", 32'(ld_pending_o), 32'd1);
            check("ld_wait_rd", 32'(ld_rd_o), 32'(rd));
            if (i == delay) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = word;
            end
            @(negedge clk);
        end
        mem_rvalid_i = 1'b0;
        check("ld_we", 32'(we_o), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            check("ld_waddr", 32'(waddr_o), 32'(rd));
            check("ld_wdata", wdata_o, ref_ext(f3, lo, word));
        end
        check_idle("ld_end");
    endtask

    task automatic timeout_load(input logic [4:0] rd);
        ex_valid_i   = 1'b1;
        ex_is_load_i = 1'b1;
        ex_rd_i      = rd;
        ex_funct3_i  = 3'd2;
        ex_addr_lo_i = 2'd0;
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < TO; i++) begin
            check("to_wait_pend", 32'(ld_pending_o), 32'd1);
            check("to_wait_err", 32'(err_o), 32'(exp_err));
            check("to_wait_we", 32'(we_o), 32'd0);
            @(negedge clk);
        end
        exp_err = 1'b1;
        check("to_we", 32'(we_o), 32'd0);
        check_idle("to_end");
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("to_late_we", 32'(we_o), 32'd0);
        check_idle("to_late");
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            mem_rvalid_i = 1'($urandom);
            mem_rdata_i  = $urandom;
            @(negedge clk);
            check("idle_we", 32'(we_o), 32'd0);
            check_idle("idle");
        end
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_in = 1'b1;
        clear_inputs();
        ex_rd_i = '0; ex_result_i = '0; ex_funct3_i = '0; ex_addr_lo_i = '0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_waddr", 32'(waddr_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check_idle("rst");
        rst_in = 1'b0;
        @(negedge clk);

        b_rd[0] = 5'd5; b_res[0] = 32'hDEADBEEF;
        alu_burst(1);
        b_rd[0] = 5'd1; b_res[0] = 32'h11111111;
        b_rd[1] = 5'd2; b_res[1] = 32'h22222222;
        b_rd[2] = 5'd3; b_res[2] = 32'h33333333;
        alu_burst(3);
        b_rd[0] = 5'd0; b_res[0] = 32'h0BADF00D;
        alu_burst(1);

        load(5'd3, 3'b000, 2'd2, 32'h12803456, 0, 1'b0);
        load(5'd3, 3'b100, 2'd2, 32'h12803456, 0, 1'b0);
        load(5'd4, 3'b001, 2'd2, 32'h80010000, 1, 1'b1);
        load(5'd4, 3'b101, 2'd2, 32'h80010000, 0, 1'b0);
        load(5'd6, 3'b010, 2'd1, 32'hA5A5F00F, 0, 1'b0);
        load(5'd9, 3'b011, 2'd3, 32'h87654321, 0, 1'b0);
        load(5'd7, 3'b000, 2'd1, 32'h00007F00, 5, 1'b0);
        load(5'd8, 3'b001, 2'd0, 32'hFFFF7FFF, TO - 1, 1'b0);
        load(5'd0, 3'b010, 2'd0, 32'h12345678, 2, 1'b0);
        idle_cycles(3);
        timeout_load(5'd12);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    int n;
                    n = $urandom_range(1, 8);
                    for (int k = 0; k < n; k++) begin
                        b_rd[k]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                        b_res[k] = $urandom;
                    end
                    alu_burst(n);
                end
                1: load(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 3'($urandom),
                        2'($urandom), $urandom, $urandom_range(0, TO - 1), 1'($urandom));
                default: idle_cycles($urandom_range(1, 3));
            endcase
        end

        ex_valid_i   = 1'b1;
        ex_is_load_i = 1'b1;
        ex_rd_i      = 5'd17;
        ex_funct3_i  = 3'd2;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("mid_pend", 32'(ld_pending_o), 32'd1);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        exp_err = 1'b0;
        check("midrst_we", 32'(we_o), 32'd0);
        check("midrst_waddr", 32'(waddr_o), 32'd0);
        check("midrst_wdata", wdata_o, 32'd0);
        check_idle("midrst");
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h13572468;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("postrst_we", 32'(we_o), 32'd0);
        check_idle("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_wb.md
# cpu_wb

Write-back stage of the RV32 core. Accepts completed results from the execute stage, waits for data-bus responses on loads, performs RV32I load byte/halfword selection and sign/zero extension, and drives the register file write port (`we`/`waddr`/`wdata`). It also exports the pending-load destination so decode can stall on load-use hazards.

## Interface
- `TIMEOUT`, 16: maximum cycles spent in WAIT_LOAD before the load is abandoned (legal range 2..255).
- `clk_in`  in  1  clock; all state updates on its rising edge.
- `rst_in`  in  1  reset; synchronous, active-high.
- `ex_valid_i`  in  1  execute stage presents a result.
- `ex_ready_o`  out  1  stage can accept; equals 1 exactly when state is IDLE.
- `ex_rd_i`  in  5  destination register.
- `ex_result_i`  in  32  ALU result (non-load only).
- `ex_is_load_i`  in  1  transaction is a load; data arrives on the memory response.
- `ex_funct3_i`  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `ex_addr_lo_i`  in  2  load address bits [1:0].
- `mem_rvalid_i`  in  1  data-bus read response valid.
- `mem_rdata_i`  in  32  data-bus read word (aligned word).
- `we_o`  out  1  register file write enable.
- `waddr_o`  out  5  register file write address.
- `wdata_o`  out  32  register file write data.
- `ld_pending_o`  out  1  a load is outstanding (state WAIT_LOAD).
- `ld_rd_o`  out  5  destination of the outstanding load; 0 when none.
- `err_o`  out  1  sticky load-timeout flag.

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE, handshake (`ex_valid_i & ex_ready_o`), non-load: register `ex_rd_i`/`ex_result_i`; next cycle `we_o`=1 with them; stay IDLE.
- IDLE, handshake, load: latch rd, funct3, addr_lo; clear timeout counter; go WAIT_LOAD. `we_o`=0 next cycle.
- WAIT_LOAD: `ex_ready_o`=0; counter increments every cycle without `mem_rvalid_i`.
- WAIT_LOAD with `mem_rvalid_i`: extend data, next cycle `we_o`=1, `waddr_o`=latched rd, `wdata_o`=extended; go IDLE.
- Extension: byte = `mem_rdata_i[8*addr_lo +: 8]`; half = addr_lo[1] ? bits[31:16] : bits[15:0] (addr_lo[0] ignored). LB/LH sign-extend, LBU/LHU zero-extend, LW passes word. funct3 011/110/111 treated as LW.
- Timeout: counter reaching `TIMEOUT`-1 with no `mem_rvalid_i` that cycle → set `err_o`, go IDLE, no write. `mem_rvalid_i` on that same cycle wins (normal write, no error).
- rd = 0: handshake and state flow unchanged but `we_o` stays 0 (regfile also ignores x0; this stage never asserts it).
- `mem_rvalid_i` in IDLE is ignored (no write, no error).
- `err_o` clears only on reset.

## Timing
- Reset values: state IDLE, `we_o`=0, `waddr_o`=0, `wdata_o`=0, `ld_pending_o`=0, `ld_rd_o`=0, `err_o`=0, counter 0; `ex_ready_o`=1 from the first cycle after reset.
- Reset mid-WAIT_LOAD abandons the load; a response arriving after reset is ignored.
- Non-load latency: 1 cycle handshake → `we_o` pulse. Back-to-back non-loads sustain one write per cycle.
- Load latency: write 1 cycle after the `mem_rvalid_i` cycle; earliest response is the cycle after acceptance (a response in the accept cycle is ignored).
- `we_o` is a single-cycle pulse per write; all outputs registered except `ex_ready_o` (decoded from state).
- `ld_pending_o`/`ld_rd_o` valid from the cycle after load acceptance through the cycle `mem_rvalid_i` is seen; deassert with the transition to IDLE.

## Test plan
- Reset, then non-load rd=5, result 0xDEADBEEF → `we_o`=1, `waddr_o`=5, `wdata_o`=0xDEADBEEF exactly one cycle later; three back-to-back ALU results produce three consecutive pulses.
- LB rd=3, addr_lo=2, response 0x12_80_34_56 → `wdata_o`=0xFFFFFF80; LBU same → 0x00000080; LH addr_lo=2 resp 0x8001_0000 → 0xFFFF8001; LHU → 0x00008001; LW → word unchanged.
- Load with response after 5 cycles → `ex_ready_o`=0 and `ld_pending_o`=1, `ld_rd_o`=rd for those cycles; write one cycle after response; `ex_ready_o`=1 again.
- TIMEOUT=4, no response → `err_o` sets after 4 WAIT_LOAD cycles, no write, back to IDLE; late `mem_rvalid_i` ignored; response on the 4th cycle instead → normal write, `err_o`=0.
- rd=0 ALU op and rd=0 load → no `we_o` pulse; load still waits for response.
- Assert `rst_in` mid-WAIT_LOAD, then `mem_rvalid_i` → all outputs at reset values, no write.
